// File: rtl/fifo_wr_pkg.sv
// Shared types and constants for the FIFO burst writer and its pattern generator.
package fifo_wr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } wr_state_e;

  // Fibonacci taps 8,6,5,4 expressed as a mask over data[7:0] (bits 7,5,4,3)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic MODE_INC  = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

endpackage

// File: rtl/fifo_wr_patgen.sv
// Data-word pattern generator: holds the current word and steps it by increment or LFSR.
// The LFSR step is defined for an 8-bit word.
module fifo_wr_patgen
  import fifo_wr_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] seed_i,
  input  logic                  mode_i,
  input  logic                  advance_i,
  output logic [DATA_WIDTH-1:0] word_o
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] inc_next_s;
  logic [DATA_WIDTH-1:0] lfsr_next_s;

  // Next-word candidates and load/advance selection
  always_comb begin
    inc_next_s  = data_q + DATA_WIDTH'(1);
    lfsr_next_s = {data_q[DATA_WIDTH-2:0], ^(data_q[7:0] & LFSR_TAPS)};
    data_d      = data_q;
    mode_d      = mode_q;
    if (load_i) begin
      mode_d = mode_i;
      // An all-zero LFSR state would lock up, so a zero seed starts at 1
      if ((mode_i == MODE_LFSR) && (seed_i == '0)) begin
        data_d = DATA_WIDTH'(1);
      end else begin
        data_d = seed_i;
      end
    end else if (advance_i) begin
      if (mode_q == MODE_INC) begin
        data_d = inc_next_s;
      end else begin
        data_d = lfsr_next_s;
      end
    end else begin
      data_d = data_q;
    end
  end

  // Data and mode registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q <= '0;
      mode_q <= MODE_INC;
    end else begin
      data_q <= data_d;
      mode_q <= mode_d;
    end
  end

  assign word_o = data_q;

endmodule

// File: rtl/fifo_burst_writer.sv
// Write-side burst producer for the async FIFO: pushes seeded word bursts, stalling on fifo_full.
// Optional FIFO_WR_CHECKSUM_EN builds an XOR checksum of written words; otherwise checksum is 0.
module fifo_burst_writer
  import fifo_wr_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  mode,
  input  logic                  abort,
  input  logic                  fifo_full,
  output logic                  write_enable,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_written,
  output logic [DATA_WIDTH-1:0] checksum
);

  // The reset input keeps its legacy name but is asserted high
  logic rst_s;
  assign rst_s = wrst_n;

  wr_state_e             state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  count_q, count_d;
  logic                  busy_q, done_q;
  logic                  we_s;
  logic                  start_acc_s;
  logic                  load_s;
  logic [LEN_WIDTH-1:0]  count_inc_s;

  // Next-state, counter and capture logic
  always_comb begin
    we_s        = (state_q == WRITE) && !fifo_full && !abort;
    start_acc_s = (state_q == IDLE) && start;
    count_inc_s = count_q + LEN_WIDTH'(1);
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    load_s      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          count_d = '0;
          if (burst_len != '0) begin
            state_d = WRITE;
            len_d   = burst_len;
            load_s  = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (abort) begin
          state_d = DONE;
        end else if (we_s) begin
          count_d = count_inc_s;
          if (count_inc_s == len_q) begin
            state_d = DONE;
          end else begin
            state_d = WRITE;
          end
        end else begin
          state_d = WRITE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state, captured length, write count and registered status flags
  always_ff @(posedge wclk or posedge rst_s) begin
    if (rst_s) begin
      state_q <= IDLE;
      len_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      busy_q  <= (state_d == WRITE);
      done_q  <= (state_d == DONE);
    end
  end

  fifo_wr_patgen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_patgen (
    .clk_i     (wclk),
    .rst_i     (rst_s),
    .load_i    (load_s),
    .seed_i    (seed),
    .mode_i    (mode),
    .advance_i (we_s),
    .word_o    (data_in)
  );

`ifdef FIFO_WR_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] cks_q, cks_d;

  // Checksum next value: cleared on a new command, folded in on each write
  always_comb begin
    if (start_acc_s) begin
      cks_d = '0;
    end else if (we_s) begin
      cks_d = cks_q ^ data_in;
    end else begin
      cks_d = cks_q;
    end
  end

  // Checksum accumulator
  always_ff @(posedge wclk or posedge rst_s) begin
    if (rst_s) begin
      cks_q <= '0;
    end else begin
      cks_q <= cks_d;
    end
  end

  assign checksum = cks_q;
`else
  logic unused_start_acc_s;
  assign unused_start_acc_s = start_acc_s;
  assign checksum = '0;
`endif

  assign write_enable  = we_s;
  assign busy          = busy_q;
  assign done          = done_q;
  assign words_written = count_q;

endmodule

// File: tb/tb_fifo_burst_writer.sv
// Directed self-checking bench for fifo_burst_writer (incrementing, LFSR, stall, abort, edge commands).
module tb_fifo_burst_writer;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       start;
  logic [9:0] burst_len;
  logic [7:0] seed;
  logic       mode;
  logic       abort;
  logic       fifo_full;
  logic       write_enable;
  logic [7:0] data_in;
  logic       busy;
  logic       done;
  logic [9:0] words_written;
  logic [7:0] checksum;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [7:0] wq[$];
  int         done_cnt = 0;

  fifo_burst_writer #(.DATA_WIDTH(8), .LEN_WIDTH(10)) dut (
    .wclk          (wclk),
    .wrst_n        (wrst_n),
    .start         (start),
    .burst_len     (burst_len),
    .seed          (seed),
    .mode          (mode),
    .abort         (abort),
    .fifo_full     (fifo_full),
    .write_enable  (write_enable),
    .data_in       (data_in),
    .busy          (busy),
    .done          (done),
    .words_written (words_written),
    .checksum      (checksum)
  );

  always #5 wclk = ~wclk;

  // Record every word the FIFO would capture and every done pulse
  always @(posedge wclk) begin
    if (write_enable) wq.push_back(data_in);
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic issue_start(input logic [9:0] len, input logic [7:0] sd, input logic md);
    @(negedge wclk);
    start = 1'b1; burst_len = len; seed = sd; mode = md;
    @(negedge wclk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      #1;
      if (done) begin seen = 1'b1; break; end
      @(negedge wclk);
    end
  endtask

  function automatic logic [7:0] xor_inc(input logic [7:0] sd, input int n);
    logic [7:0] acc = 8'h00;
    for (int i = 0; i < n; i++) acc = acc ^ (sd + 8'(i));
    return acc;
  endfunction

  function automatic logic [7:0] exp_cks(input logic [7:0] v);
`ifdef FIFO_WR_CHECKSUM_EN
    return v;
`else
    return 8'h00 & v;
`endif
  endfunction

  initial begin
    int  base;
    int  errs;
    int  dbase;
    bit  seen;
    logic [7:0] e;

    wrst_n = 1'b1; start = 1'b0; burst_len = 10'd0; seed = 8'h00;
    mode = 1'b0; abort = 1'b0; fifo_full = 1'b0;

    // Reset held for 5 cycles
    repeat (5) @(negedge wclk);
    #1;
    chk("rst_we", write_enable, 1'b0);
    chk("rst_data", data_in, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ww", words_written, 10'd0);
    chk("rst_cks", checksum, 8'h00);
    wrst_n = 1'b0;
    repeat (3) @(negedge wclk);
    #1;
    chk("idle_nowrite", wq.size(), 0);
    chk("idle_busy", busy, 1'b0);

    // Incrementing burst with wrap
    base = wq.size();
    issue_start(10'd4, 8'hFE, 1'b0);
    e = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("inc_we%0d", i), write_enable, 1'b1);
      chk($sformatf("inc_busy%0d", i), busy, 1'b1);
      chk($sformatf("inc_data%0d", i), data_in, e);
      e = e + 8'h01;
      @(negedge wclk);
    end
    #1;
    chk("inc_done", done, 1'b1);
    chk("inc_busy_fall", busy, 1'b0);
    chk("inc_we_off", write_enable, 1'b0);
    chk("inc_ww", words_written, 10'd4);
    chk("inc_cks", checksum, exp_cks(8'h00));
    chk("inc_count", wq.size() - base, 4);
    @(negedge wclk);
    #1;
    chk("inc_done_pulse", done, 1'b0);

    // LFSR with zero seed
    base = wq.size();
    issue_start(10'd3, 8'h00, 1'b1);
    wait_done(20, seen);
    chk("lfsr_done_seen", seen, 1'b1);
    chk("lfsr_count", wq.size() - base, 3);
    if (wq.size() - base == 3) begin
      chk("lfsr_w0", wq[base], 8'h01);
      chk("lfsr_w1", wq[base+1], 8'h02);
      chk("lfsr_w2", wq[base+2], 8'h04);
    end else begin
      chk("lfsr_words_present", wq.size() - base, 3);
    end
    chk("lfsr_cks", checksum, exp_cks(8'h07));

    // Long burst with a 10-cycle full stall after 100 writes
    base = wq.size();
    issue_start(10'd512, 8'h10, 1'b0);
    repeat (100) @(negedge wclk);
    fifo_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("stall_we%0d", i), write_enable, 1'b0);
      chk($sformatf("stall_data%0d", i), data_in, 8'h74);
      @(negedge wclk);
    end
    #1;
    chk("stall_ww", words_written, 10'd100);
    chk("stall_busy", busy, 1'b1);
    fifo_full = 1'b0;
    #1;
    chk("stall_resume_we", write_enable, 1'b1);
    chk("stall_resume_data", data_in, 8'h74);
    @(negedge wclk);
    wait_done(1000, seen);
    chk("stall_done_seen", seen, 1'b1);
    chk("stall_ww_final", words_written, 10'd512);
    chk("stall_count", wq.size() - base, 512);
    errs = 0;
    for (int i = 0; i < 512 && (base + i) < wq.size(); i++) begin
      e = 8'h10 + 8'(i);
      if (wq[base+i] !== e) errs++;
    end
    chk("stall_seq_errs", errs, 0);
    chk("stall_cks", checksum, exp_cks(xor_inc(8'h10, 512)));

    // Abort at 7 of 20
    base = wq.size();
    issue_start(10'd20, 8'h30, 1'b0);
    repeat (7) @(negedge wclk);
    abort = 1'b1;
    #1;
    chk("abort_we", write_enable, 1'b0);
    chk("abort_ww_at", words_written, 10'd7);
    @(negedge wclk);
    abort = 1'b0;
    #1;
    chk("abort_done", done, 1'b1);
    chk("abort_ww", words_written, 10'd7);
    chk("abort_count", wq.size() - base, 7);
    chk("abort_cks", checksum, exp_cks(xor_inc(8'h30, 7)));

    // Zero-length command
    base = wq.size();
    issue_start(10'd0, 8'h55, 1'b0);
    #1;
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    chk("zero_we", write_enable, 1'b0);
    chk("zero_ww", words_written, 10'd0);
    chk("zero_cks", checksum, 8'h00);
    @(negedge wclk);
    #1;
    chk("zero_count", wq.size() - base, 0);

    // Start while busy is ignored
    base = wq.size();
    issue_start(10'd5, 8'h80, 1'b0);
    @(negedge wclk);
    start = 1'b1; burst_len = 10'd3; seed = 8'h00; mode = 1'b1;
    @(negedge wclk);
    start = 1'b0;
    wait_done(20, seen);
    chk("busy_start_done", seen, 1'b1);
    chk("busy_start_ww", words_written, 10'd5);
    chk("busy_start_count", wq.size() - base, 5);
    if (wq.size() - base == 5) begin
      chk("busy_start_last", wq[base+4], 8'h84);
    end else begin
      chk("busy_start_words_present", wq.size() - base, 5);
    end
    repeat (3) @(negedge wclk);
    #1;
    chk("busy_start_no_requeue", busy, 1'b0);

    // Reset mid-burst
    issue_start(10'd50, 8'h00, 1'b0);
    repeat (5) @(negedge wclk);
    dbase = done_cnt;
    wrst_n = 1'b1;
    #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_we", write_enable, 1'b0);
    chk("mrst_data", data_in, 8'h00);
    chk("mrst_ww", words_written, 10'd0);
    repeat (2) @(negedge wclk);
    wrst_n = 1'b0;
    repeat (4) @(negedge wclk);
    #1;
    chk("mrst_no_done", done_cnt - dbase, 0);
    chk("mrst_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_burst_writer.md
# fifo_burst_writer

Write-side traffic producer for the async FIFO. Accepts a burst command (length, seed, pattern mode), then generates and pushes data words into the FIFO write port in the `wclk` domain, throttling on `fifo_full` so that no word is ever dropped. Reports completion and a write count. It sits in front of `async_fifo_top` as the write-port counterpart to the read-side consumer.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: FIFO word width. LFSR mode is defined for 8 only.
- `LEN_WIDTH`, default 10: burst length counter width.

Ports:
- `wclk`, input, 1: write-domain clock.
- `wrst_n`, input, 1: reset, asynchronous, active-high.
- `start`, input, 1: burst command strobe, sampled in IDLE only.
- `burst_len`, input, LEN_WIDTH: number of words to write, captured on accepted `start`.
- `seed`, input, DATA_WIDTH: first data word, captured on accepted `start`.
- `mode`, input, 1: 0 = incrementing, 1 = LFSR. Captured on accepted `start`.
- `abort`, input, 1: terminate the active burst.
- `fifo_full`, input, 1: FIFO full flag, synchronous to `wclk`.
- `write_enable`, output, 1: FIFO write strobe.
- `data_in`, output, DATA_WIDTH: FIFO write data.
- `busy`, output, 1: high in WRITE.
- `done`, output, 1: single-cycle pulse at burst end.
- `words_written`, output, LEN_WIDTH: writes issued in the current or last burst.
- `checksum`, output, DATA_WIDTH: see Configuration.

## Operation
- FSM states: IDLE, WRITE, DONE.
- IDLE -> WRITE on `start` when `burst_len != 0`. This captures length, mode and data register = `seed`, and clears `words_written`.
- IDLE -> DONE on `start` when `burst_len == 0`. No writes occur.
- WRITE -> DONE when the last word is written (`words_written` reaches `burst_len`) or when `abort` is high.
- DONE -> IDLE unconditionally after 1 cycle. `done` is high only in DONE.
- `write_enable` = (state == WRITE) && !`fifo_full` && !`abort`. It is combinational from the state register and inputs, and is the only combinational output.
- When `write_enable` is high, the data register advances and `words_written` increments.
  - Incrementing mode: next = data + 1, modulo 2^DATA_WIDTH (0xFF wraps to 0x00).
  - LFSR mode: Fibonacci, taps 8,6,5,4. next = {data[6:0], data[7]^data[5]^data[4]^data[3]}. A seed of 0 in LFSR mode is replaced by 0x01 at capture.
- `start` in WRITE or DONE is ignored, not queued.
- `fifo_full` high stalls in WRITE. Data and count hold, with no limit on stall length.
- `abort` has priority over a write in the same cycle. `words_written` keeps the count reached.
- Reset values:
  - state IDLE
  - `write_enable` 0, `data_in` 0, `busy` 0, `done` 0
  - `words_written` 0, `checksum` 0
- Reset assertion mid-burst returns the block to IDLE immediately. No `done` pulse is produced.

## Timing
- `start` accepted at edge N: `busy` is high and the first write is possible in cycle N+1.
- With `fifo_full` low throughout, burst length L occupies L consecutive `write_enable` cycles. `done` is asserted in cycle N+L+1 and `busy` falls in that same cycle.
- Start-to-start minimum is L+2 cycles.
- `data_in` is registered and valid whenever `write_enable` is high. The FIFO captures it at that same edge.
- `fifo_full` rising in cycle K blocks the write in cycle K. There is zero-cycle reaction, so overflow is impossible.

## Configuration
- `FIFO_WR_CHECKSUM_EN` defined:
  - `checksum` = XOR of every word written in the burst.
  - Cleared on accepted `start`, updated on each `write_enable`, held after DONE until the next start.
- `FIFO_WR_CHECKSUM_EN` undefined:
  - `checksum` is tied to 0.
  - No accumulator register is built.
  - The port remains so instantiations do not change.

## Structure
- Shared package `fifo_wr_pkg`:
  - state enum (`IDLE`, `WRITE`, `DONE`)
  - LFSR tap constant
  - mode encoding constants (`MODE_INC`, `MODE_LFSR`)
- One sub-module, `fifo_wr_patgen`:
  - inputs: load, seed, mode, advance
  - output: current word
  - owns the data register and both next-word functions.
- The FSM, counters and checksum stay in the top module.

## Test plan
- Reset: hold `wrst_n`=1 for 5 cycles -> all outputs 0, state IDLE; release, no writes without `start`.
- Incrementing burst: `seed`=0xFE, `burst_len`=4, `mode`=0, `fifo_full`=0 -> writes 0xFE,0xFF,0x00,0x01 on 4 consecutive cycles; `done` 1 cycle later; `words_written`=4; `checksum`=0x00 with macro.
- LFSR with zero seed: `seed`=0x00, `mode`=1, `burst_len`=3 -> writes 0x01,0x02,0x04.
- Full stall: `burst_len`=512, `fifo_full` forced high for 10 cycles mid-burst -> no `write_enable` during the stall; data resumes at the held word; total writes exactly 512.
- Abort: `abort` pulsed when `words_written`=7 of 20 -> no write that cycle; `done` next cycle; `words_written` stays 7.
- Edge commands: `burst_len`=0 -> `done` pulse, zero writes. `start` while busy -> ignored. Reset mid-burst -> IDLE, no `done`.
